// File: rtl/issue_unit.sv
// Issue arbiter: grants at most one op per queue each cycle, combinationally, with 0-cycle latency from Ready.
// A queue that cannot be granted is back-pressured by leaving its grant low; the queue keeps Ready asserted.
module issue_unit #(
   parameter int INT_LAT = 1,
   parameter int LSB_LAT = 1,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 7
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               IssInt_Ready,
   input  logic               IssMul_Ready,
   input  logic               IssDiv_Ready,
   input  logic               IssLsb_Ready,
   input  logic               RB_Flush_Valid,
   output logic               Iss_Int,
   output logic               Iss_Mul,
   output logic               Iss_Div,
   output logic               Iss_Lsb,
   output logic               Div_Busy,
   output logic [DIV_LAT-1:0] Cdb_Res
);

   localparam int CW = $clog2(DIV_LAT + 1);

   logic [DIV_LAT:1] res;
   logic [DIV_LAT:1] res_nxt;
   logic [CW-1:0]    div_cnt;
   logic [CW-1:0]    div_cnt_nxt;
   logic             lru;
   logic             lru_nxt;

   logic             no_issue;
   logic             div_idle;
   logic             short_slot_free;

   assign no_issue        = Rst | RB_Flush_Valid;
   assign div_idle        = (div_cnt == '0);
   assign short_slot_free = ~res[INT_LAT];

   // Int and ld/st share the latency-1 CDB slot, so only one of them may go per cycle.
   always_comb begin
      Iss_Int = 1'b0;
      Iss_Mul = 1'b0;
      Iss_Div = 1'b0;
      Iss_Lsb = 1'b0;
      if (!no_issue) begin
         Iss_Div = IssDiv_Ready & div_idle & ~res[DIV_LAT];
         Iss_Mul = IssMul_Ready & ~res[MUL_LAT];
         if (short_slot_free) begin
            if (IssInt_Ready && IssLsb_Ready) begin
               Iss_Int = ~lru;
               Iss_Lsb = lru;
            end else begin
               Iss_Int = IssInt_Ready;
               Iss_Lsb = IssLsb_Ready;
            end
         end
      end
   end

   always_comb begin
      res_nxt = '0;
      for (int k = 1; k < DIV_LAT; k++) begin
         res_nxt[k] = res[k+1];
      end
      if (Iss_Int) res_nxt[INT_LAT] = 1'b1;
      if (Iss_Lsb) res_nxt[LSB_LAT] = 1'b1;
      if (Iss_Mul) res_nxt[MUL_LAT] = 1'b1;
      if (Iss_Div) res_nxt[DIV_LAT] = 1'b1;

      if (Iss_Div) begin
         div_cnt_nxt = CW'(DIV_LAT);
      end else if (!div_idle) begin
         div_cnt_nxt = div_cnt - CW'(1);
      end else begin
         div_cnt_nxt = '0;
      end

      // A flush squashes everything in flight but keeps the int/lsb fairness history.
      if (RB_Flush_Valid) begin
         res_nxt     = '0;
         div_cnt_nxt = '0;
      end

      lru_nxt = lru;
      if (Iss_Int) begin
         lru_nxt = 1'b1;
      end else if (Iss_Lsb) begin
         lru_nxt = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         res     <= '0;
         div_cnt <= '0;
         lru     <= 1'b0;
      end else begin
         res     <= res_nxt;
         div_cnt <= div_cnt_nxt;
         lru     <= lru_nxt;
      end
   end

   assign Div_Busy = ~div_idle;
   assign Cdb_Res  = res;

   a_short_exclusive : assert property (@(posedge Clk) disable iff (Rst) !(Iss_Int && Iss_Lsb));
   a_flush_quiet     : assert property (@(posedge Clk) disable iff (Rst)
                                       RB_Flush_Valid |-> !(Iss_Int || Iss_Mul || Iss_Div || Iss_Lsb));
   a_div_not_busy    : assert property (@(posedge Clk) disable iff (Rst) Iss_Div |-> !Div_Busy);

endmodule

// File: tb/tb_issue_unit.sv
// Directed table of per-cycle {inputs, expected outputs} for issue_unit, plus hand-written async-reset sequences.
module tb_issue_unit;

   logic       Clk;
   logic       Rst;
   logic       IssInt_Ready, IssMul_Ready, IssDiv_Ready, IssLsb_Ready;
   logic       RB_Flush_Valid;
   logic       Iss_Int, Iss_Mul, Iss_Div, Iss_Lsb;
   logic       Div_Busy;
   logic [6:0] Cdb_Res;

   int errors = 0;
   int checks = 0;

   issue_unit #(.INT_LAT(1), .LSB_LAT(1), .MUL_LAT(4), .DIV_LAT(7)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .IssInt_Ready   (IssInt_Ready),
      .IssMul_Ready   (IssMul_Ready),
      .IssDiv_Ready   (IssDiv_Ready),
      .IssLsb_Ready   (IssLsb_Ready),
      .RB_Flush_Valid (RB_Flush_Valid),
      .Iss_Int        (Iss_Int),
      .Iss_Mul        (Iss_Mul),
      .Iss_Div        (Iss_Div),
      .Iss_Lsb        (Iss_Lsb),
      .Div_Busy       (Div_Busy),
      .Cdb_Res        (Cdb_Res)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // rdy and gnt are both ordered {int, mul, div, lsb}; res is Cdb_Res (bit k-1 = res[k]).
   typedef struct packed {
      logic       rst;
      logic [3:0] rdy;
      logic       flush;
      logic [3:0] gnt;
      logic       busy;
      logic [6:0] res;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic [3:0] rdy, input logic flush,
                      input logic [3:0] gnt, input logic busy, input logic [6:0] res);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.flush = flush;
      v.gnt = gnt; v.busy = busy; v.res = res;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", nm, idx, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] rdy, input logic flush);
      {IssInt_Ready, IssMul_Ready, IssDiv_Ready, IssLsb_Ready} = rdy;
      RB_Flush_Valid = flush;
   endtask

   function automatic logic [3:0] gnts();
      return {Iss_Int, Iss_Mul, Iss_Div, Iss_Lsb};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst = 1'b1;
      drive(4'b0000, 1'b0);

      // reset: everything ready but nothing granted
      add(1, 4'b1111, 0, 4'b0000, 0, 7'h00);
      // int+lsb both ready: own latency-1 claim in res[1] blocks the following cycle
      add(0, 4'b1001, 0, 4'b1000, 0, 7'h00);
      add(0, 4'b1001, 0, 4'b0000, 0, 7'h01);
      add(0, 4'b1001, 0, 4'b0001, 0, 7'h00);
      add(0, 4'b1001, 0, 4'b0000, 0, 7'h01);
      add(0, 4'b1001, 0, 4'b1000, 0, 7'h00);
      add(0, 4'b0000, 0, 4'b0000, 0, 7'h01);
      // mul+div same cycle, then div held ready until the divider frees up
      add(0, 4'b0110, 0, 4'b0110, 0, 7'h00);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h48);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h24);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h12);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h09);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h04);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h02);
      add(0, 4'b0010, 0, 4'b0000, 1, 7'h01);
      add(0, 4'b0010, 0, 4'b0010, 0, 7'h00);
      // flush two cycles after a div grant
      add(0, 4'b0000, 0, 4'b0000, 1, 7'h40);
      add(0, 4'b1111, 1, 4'b0000, 1, 7'h20);
      add(0, 4'b0010, 0, 4'b0010, 0, 7'h00);
      add(0, 4'b0000, 1, 4'b0000, 1, 7'h40);
      // mul claim walks down to res[1]; int collides with it only once it reaches res[1]
      add(0, 4'b0100, 0, 4'b0100, 0, 7'h00);
      add(0, 4'b0000, 0, 4'b0000, 0, 7'h08);
      add(0, 4'b0000, 0, 4'b0000, 0, 7'h04);
      add(0, 4'b1000, 0, 4'b1000, 0, 7'h02);
      add(0, 4'b1000, 0, 4'b0000, 0, 7'h01);
      add(0, 4'b1001, 0, 4'b0001, 0, 7'h00);
      add(0, 4'b0000, 0, 4'b0000, 0, 7'h01);
      add(0, 4'b1000, 0, 4'b1000, 0, 7'h00);
      add(0, 4'b0000, 0, 4'b0000, 0, 7'h01);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge Clk);
         #1;
         Rst = vecs[i].rst;
         drive(vecs[i].rdy, vecs[i].flush);
         @(negedge Clk);
         chk("grants",   i, {4'b0, gnts()},      {4'b0, vecs[i].gnt});
         chk("div_busy", i, {7'b0, Div_Busy},    {7'b0, vecs[i].busy});
         chk("cdb_res",  i, {1'b0, Cdb_Res},     {1'b0, vecs[i].res});
      end

      // all four ready with lru=1: div, mul, lsb granted; async reset mid-cycle kills them
      @(posedge Clk); #1;
      drive(4'b1111, 1'b0);
      @(negedge Clk);
      chk("all_ready_grants", 100, {4'b0, gnts()}, 8'b0000_0111);
      #2 Rst = 1'b1;
      #1;
      chk("rst_mid_grants", 101, {4'b0, gnts()}, 8'h00);
      chk("rst_mid_busy",   101, {7'b0, Div_Busy}, 8'h00);
      chk("rst_mid_res",    101, {1'b0, Cdb_Res}, 8'h00);

      // after reset lru is back to 0, so int wins the shared slot
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("post_rst_grants", 102, {4'b0, gnts()}, 8'b0000_1110);
      chk("post_rst_res",    102, {1'b0, Cdb_Res}, 8'h00);

      // reset while div, mul and int are all in flight
      @(posedge Clk); #1;
      drive(4'b0000, 1'b0);
      @(negedge Clk);
      chk("inflight_busy", 103, {7'b0, Div_Busy}, 8'h01);
      chk("inflight_res",  103, {1'b0, Cdb_Res}, 8'h49);
      #2 Rst = 1'b1;
      #1;
      chk("rst_inflight_busy", 104, {7'b0, Div_Busy}, 8'h00);
      chk("rst_inflight_res",  104, {1'b0, Cdb_Res}, 8'h00);

      @(posedge Clk); #1;
      Rst = 1'b0;
      drive(4'b0010, 1'b0);
      @(negedge Clk);
      chk("div_after_rst", 105, {4'b0, gnts()}, 8'b0000_0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
